cache_set_engine: RTL and testbench

//  Parametrised set-associative tag/state/replacement engine for one L1 cache (data or instr).

---
 rtl/cache_set_engine.sv | 242 ++++++++++++++++++++++++
 tb/tb_cache_set_engine.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cache_set_engine.sv
// Set-associative tag / MESI / true-LRU engine for one L1 cache, one command in flight.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module cache_set_engine #(
  parameter  int WAYS  = 8,
  parameter  int SETS  = 16,
  parameter  int TAG_W = 12,
  localparam int AGE_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_cmd,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             snoop_shared,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic [AGE_W-1:0] resp_way,
  output logic [1:0]       resp_mesi,
  output logic             resp_wb,
  output logic [TAG_W-1:0] resp_wb_tag
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses,
  output logic [31:0]      stat_wbs
`endif
);

  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_INVAL = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;
  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_FLUSH, S_RESP} state_t;

  state_t           state_q;
  logic [TAG_W-1:0] tag_q  [SETS][WAYS];
  logic [1:0]       mesi_q [SETS][WAYS];
  logic [AGE_W-1:0] age_q  [SETS][WAYS];
  logic [1:0]       cmd_q;
  logic [IDX_W-1:0] idx_q, flush_idx_q;
  logic [TAG_W-1:0] cap_tag_q;
  logic             snoop_q, hit_q, req_ready_q;
  logic [AGE_W-1:0] way_q;
  logic             resp_valid_q, resp_hit_q, resp_wb_q;
  logic [AGE_W-1:0] resp_way_q;
  logic [1:0]       resp_mesi_q;
  logic [TAG_W-1:0] resp_wb_tag_q;

  logic             lk_hit_s;
  logic [AGE_W-1:0] lk_way_s, vic_way_s;
  logic [1:0]       cur_mesi_s, upd_mesi_s, rsp_mesi_s;
  logic [TAG_W-1:0] cur_tag_s;
  logic             upd_install_s, upd_touch_s, upd_wb_s;
  logic [AGE_W-1:0] rsp_way_s;

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_way    = resp_way_q;
  assign resp_mesi   = resp_mesi_q;
  assign resp_wb     = resp_wb_q;
  assign resp_wb_tag = resp_wb_tag_q;

  // Descending scans so the lowest matching / lowest invalid way wins; any I way beats the LRU way.
  always_comb begin
    lk_hit_s  = 1'b0;
    lk_way_s  = '0;
    vic_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_q[idx_q][w] == AGE_W'(WAYS - 1)) vic_way_s = AGE_W'(w);
      else vic_way_s = vic_way_s;
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mesi_q[idx_q][w] == MESI_I) vic_way_s = AGE_W'(w);
      else if (tag_q[idx_q][w] == cap_tag_q) begin
        lk_hit_s = 1'b1;
        lk_way_s = AGE_W'(w);
      end else lk_hit_s = lk_hit_s;
    end
  end

  // Per-command state change and response for the selected way of the captured set.
  always_comb begin
    cur_mesi_s    = mesi_q[idx_q][way_q];
    cur_tag_s     = tag_q[idx_q][way_q];
    upd_mesi_s    = cur_mesi_s;
    upd_install_s = 1'b0;
    upd_touch_s   = 1'b0;
    upd_wb_s      = 1'b0;
    rsp_way_s     = way_q;
    rsp_mesi_s    = cur_mesi_s;
    case (cmd_q)
      CMD_READ, CMD_WRITE: begin
        upd_touch_s = 1'b1;
        if (!hit_q) begin
          upd_install_s = 1'b1;
          upd_wb_s      = (cur_mesi_s == MESI_M);
        end else upd_install_s = 1'b0;
        if (cmd_q == CMD_WRITE) upd_mesi_s = MESI_M;
        else if (!hit_q) upd_mesi_s = snoop_q ? MESI_S : MESI_E;
        else upd_mesi_s = cur_mesi_s;
        rsp_mesi_s = upd_mesi_s;
      end
      CMD_INVAL: begin
        if (hit_q) begin
          upd_mesi_s = MESI_I;
          rsp_mesi_s = MESI_I;
        end else begin
          rsp_way_s  = '0;
          rsp_mesi_s = mesi_q[idx_q][0];
        end
      end
      default: upd_mesi_s = cur_mesi_s;
    endcase
  end

  // Control FSM, array updates and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
      resp_mesi_q   <= 2'd0;
      resp_wb_q     <= 1'b0;
      resp_wb_tag_q <= '0;
      cmd_q         <= 2'd0;
      idx_q         <= '0;
      flush_idx_q   <= '0;
      cap_tag_q     <= '0;
      snoop_q       <= 1'b0;
      hit_q         <= 1'b0;
      way_q         <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          mesi_q[s][w] <= MESI_I;
          age_q[s][w]  <= AGE_W'(w);
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            cmd_q       <= req_cmd;
            idx_q       <= req_idx;
            cap_tag_q   <= req_tag;
            snoop_q     <= snoop_shared;
            flush_idx_q <= '0;
            req_ready_q <= 1'b0;
            state_q     <= (req_cmd == CMD_CLEAR) ? S_FLUSH : S_LOOKUP;
          end else state_q <= S_IDLE;
        end
        S_LOOKUP: begin
          hit_q   <= lk_hit_s;
          way_q   <= lk_hit_s ? lk_way_s : vic_way_s;
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          mesi_q[idx_q][way_q] <= upd_mesi_s;
          if (upd_install_s) tag_q[idx_q][way_q] <= cap_tag_q;
          if (upd_touch_s) begin
            for (int w = 0; w < WAYS; w++) begin
              if (age_q[idx_q][w] < age_q[idx_q][way_q])
                age_q[idx_q][w] <= age_q[idx_q][w] + AGE_W'(1);
            end
            age_q[idx_q][way_q] <= '0;
          end
          resp_valid_q  <= 1'b1;
          resp_hit_q    <= hit_q;
          resp_way_q    <= rsp_way_s;
          resp_mesi_q   <= rsp_mesi_s;
          resp_wb_q     <= upd_wb_s;
          resp_wb_tag_q <= upd_wb_s ? cur_tag_s : '0;
          state_q       <= S_RESP;
        end
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            mesi_q[flush_idx_q][w] <= MESI_I;
            age_q[flush_idx_q][w]  <= AGE_W'(w);
          end
          flush_idx_q <= flush_idx_q + IDX_W'(1);
          if (flush_idx_q == IDX_W'(SETS - 1)) begin
            resp_valid_q  <= 1'b1;
            resp_hit_q    <= 1'b0;
            resp_way_q    <= '0;
            resp_mesi_q   <= MESI_I;
            resp_wb_q     <= 1'b0;
            resp_wb_tag_q <= '0;
            state_q       <= S_RESP;
          end else state_q <= S_FLUSH;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_way_q    <= '0;
            resp_mesi_q   <= 2'd0;
            resp_wb_q     <= 1'b0;
            resp_wb_tag_q <= '0;
            req_ready_q   <= 1'b1;
            state_q       <= S_IDLE;
          end else state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits_q, stat_misses_q, stat_wbs_q;
  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
  assign stat_wbs    = stat_wbs_q;

  // Saturating counters, counted once per READ/WRITE in UPDATE; CLEAR zeroes them at accept.
  always_ff @(posedge clk) begin
    if (rst || (state_q == S_IDLE && req_valid && req_cmd == CMD_CLEAR)) begin
      stat_hits_q   <= 32'd0;
      stat_misses_q <= 32'd0;
      stat_wbs_q    <= 32'd0;
    end else if (state_q == S_UPDATE && (cmd_q == CMD_READ || cmd_q == CMD_WRITE)) begin
      if (hit_q && stat_hits_q != 32'hFFFF_FFFF) stat_hits_q <= stat_hits_q + 32'd1;
      if (!hit_q && stat_misses_q != 32'hFFFF_FFFF) stat_misses_q <= stat_misses_q + 32'd1;
      if (upd_wb_s && stat_wbs_q != 32'hFFFF_FFFF) stat_wbs_q <= stat_wbs_q + 32'd1;
    end else begin
      stat_hits_q <= stat_hits_q;
    end
  end
`endif

endmodule

// File: tb/tb_cache_set_engine.sv
// Directed scoreboard bench for cache_set_engine (default 8-way, 16-set, 12-bit tag build).
module tb_cache_set_engine;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, snoop_shared;
  logic [1:0]  req_cmd;
  logic [3:0]  req_idx;
  logic [11:0] req_tag;
  logic        resp_valid, resp_ready, resp_hit, resp_wb;
  logic [2:0]  resp_way;
  logic [1:0]  resp_mesi;
  logic [11:0] resp_wb_tag;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_wbs;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        hit;
    logic [2:0]  way;
    logic [1:0]  mesi;
    logic        wb;
    logic [11:0] wbtag;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cache_set_engine dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_idx(req_idx), .req_tag(req_tag),
    .snoop_shared(snoop_shared), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_mesi(resp_mesi),
    .resp_wb(resp_wb), .resp_wb_tag(resp_wb_tag)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic [2:0] w, input logic [1:0] m,
                              input logic wb, input logic [11:0] wt, input logic [7:0] lat);
    mk = '{hit: h, way: w, mesi: m, wb: wb, wbtag: wt, lat: lat};
  endfunction

  task automatic fire(input logic [1:0] cmd, input logic [3:0] idx, input logic [11:0] tag,
                      input logic snp);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_cmd = cmd; req_idx = idx; req_tag = tag; snoop_shared = snp;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_cmd = cmd ^ 2'b01; req_idx = ~idx; req_tag = ~tag; snoop_shared = ~snp;
  endtask

  task automatic txn(input logic [1:0] cmd, input logic [3:0] idx, input logic [11:0] tag,
                     input logic snp, input exp_t e, input int hold);
    exp_t g;
    int cnt;
    logic [18:0] snap;
    sb.push_back(e);
    fire(cmd, idx, tag, snp);
    cnt = 0;
    while (!resp_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    g = sb.pop_front();
    chk("latency", cnt, {24'd0, g.lat});
    chk("resp_hit", {31'd0, resp_hit}, {31'd0, g.hit});
    chk("resp_way", {29'd0, resp_way}, {29'd0, g.way});
    chk("resp_mesi", {30'd0, resp_mesi}, {30'd0, g.mesi});
    chk("resp_wb", {31'd0, resp_wb}, {31'd0, g.wb});
    chk("resp_wb_tag", {20'd0, resp_wb_tag}, {20'd0, g.wbtag});
    snap = {resp_hit, resp_way, resp_mesi, resp_wb, resp_wb_tag};
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_stable", {13'd0, resp_hit, resp_way, resp_mesi, resp_wb, resp_wb_tag},
          {13'd0, snap});
      chk("hold_not_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("resp_dropped", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [7:0] seen;
    rst = 1'b1; req_valid = 1'b0; req_cmd = 2'd0; req_idx = 4'd0; req_tag = 12'd0;
    snoop_shared = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_fields", {14'd0, resp_hit, resp_way, resp_mesi, resp_wb, resp_wb_tag}, 32'd0);

    // cmd: 0 READ, 1 WRITE, 2 INVALIDATE, 3 CLEAR; MESI: I0 S1 E2 M3
    txn(2'd0, 4'd3, 12'h0AB, 1'b0, mk(1'b0, 3'd0, 2'd2, 1'b0, 12'h000, 8'd3), 0);
    txn(2'd0, 4'd3, 12'h0AB, 1'b0, mk(1'b1, 3'd0, 2'd2, 1'b0, 12'h000, 8'd3), 0);
    txn(2'd1, 4'd3, 12'h0AB, 1'b0, mk(1'b1, 3'd0, 2'd3, 1'b0, 12'h000, 8'd3), 0);
    for (int i = 0; i < 8; i++)
      txn(2'd1, 4'd5, 12'h100 + 12'(i), 1'b0, mk(1'b0, 3'(i), 2'd3, 1'b0, 12'h000, 8'd3), 0);
    txn(2'd0, 4'd5, 12'h200, 1'b0, mk(1'b0, 3'd0, 2'd2, 1'b1, 12'h100, 8'd3), 0);
    seen = 8'd0;
    for (int w = 0; w < 8; w++) seen[dut.age_q[5][w]] = 1'b1;
    chk("age_permutation", {24'd0, seen}, 32'h0000_00FF);
    chk("age_way1_lru", {29'd0, dut.age_q[5][1]}, 32'd7);
    txn(2'd2, 4'd5, 12'h103, 1'b0, mk(1'b1, 3'd3, 2'd0, 1'b0, 12'h000, 8'd3), 0);
    txn(2'd0, 4'd5, 12'h300, 1'b1, mk(1'b0, 3'd3, 2'd1, 1'b0, 12'h000, 8'd3), 0);
    txn(2'd0, 4'd5, 12'h105, 1'b0, mk(1'b1, 3'd5, 2'd3, 1'b0, 12'h000, 8'd3), 0);
    txn(2'd2, 4'd9, 12'h777, 1'b0, mk(1'b0, 3'd0, 2'd0, 1'b0, 12'h000, 8'd3), 0);
    // way1 is LRU in set 5 and holds M line 0x101
    txn(2'd1, 4'd5, 12'h400, 1'b0, mk(1'b0, 3'd1, 2'd3, 1'b1, 12'h101, 8'd3), 0);

    txn(2'd3, 4'd0, 12'h000, 1'b0, mk(1'b0, 3'd0, 2'd0, 1'b0, 12'h000, 8'd17), 5);
    txn(2'd0, 4'd3, 12'h0AB, 1'b0, mk(1'b0, 3'd0, 2'd2, 1'b0, 12'h000, 8'd3), 0);
    txn(2'd0, 4'd5, 12'h105, 1'b1, mk(1'b0, 3'd0, 2'd1, 1'b0, 12'h000, 8'd3), 0);

    txn(2'd1, 4'd12, 12'h055, 1'b0, mk(1'b0, 3'd0, 2'd3, 1'b0, 12'h000, 8'd3), 0);
    fire(2'd3, 4'd0, 12'h000, 1'b0);
    repeat (8) @(negedge clk);
    chk("flush_at_set7", {28'd0, dut.flush_idx_q}, 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    txn(2'd0, 4'd12, 12'h055, 1'b0, mk(1'b0, 3'd0, 2'd2, 1'b0, 12'h000, 8'd3), 0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
